// File: rtl/imm_decode_stage.sv
// RISC-V immediate generator with a 2-entry valid/ready skid buffer in front of ID/EX.
// Define IMMGEN_RVC_EN to decode compressed-format immediates on selector codes 8..13.
module imm_decode_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [3:0]       in_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_bad
);

  logic [XLEN-1:0]  w_imm;
  logic             w_bad;
  logic             w_sign;
  logic             w_push;
  logic             w_pop;
  logic             w_unused;

  logic [XLEN-1:0]  r_imm [2];
  logic [TAG_W-1:0] r_tag [2];
  logic             r_bad [2];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_count;

  assign w_sign   = in_instr[31];
  assign w_unused = ^in_instr[6:0];

  // All formats are built at 64 bits and truncated, so XLEN=32 and 64 share one table.
  always_comb begin
    w_imm = '0;
    w_bad = 1'b0;
    case (in_sel)
      4'd0: w_imm = XLEN'({{52{w_sign}}, in_instr[31:20]});
      4'd1: w_imm = XLEN'({{52{w_sign}}, in_instr[31:25], in_instr[11:7]});
      4'd2: w_imm = XLEN'({{51{w_sign}}, in_instr[31], in_instr[7], in_instr[30:25],
                           in_instr[11:8], 1'b0});
      4'd3: w_imm = XLEN'({{32{w_sign}}, in_instr[31:12], 12'b0});
      4'd4: w_imm = XLEN'({{43{w_sign}}, in_instr[31], in_instr[19:12], in_instr[20],
                           in_instr[30:21], 1'b0});
      4'd5: w_imm = XLEN'({59'b0, in_instr[19:15]});
      4'd6: begin
        if (XLEN == 64) w_imm = XLEN'({58'b0, in_instr[25:20]});
        else            w_imm = XLEN'({59'b0, in_instr[24:20]});
      end
`ifdef IMMGEN_RVC_EN
      4'd8:  w_imm = XLEN'({{58{in_instr[12]}}, in_instr[12], in_instr[6:2]});
      4'd9:  w_imm = XLEN'({56'b0, in_instr[8:7], in_instr[12:9], 2'b0});
      4'd10: w_imm = XLEN'({54'b0, in_instr[10:7], in_instr[12:11], in_instr[5],
                            in_instr[6], 2'b0});
      4'd11: w_imm = XLEN'({57'b0, in_instr[5], in_instr[12:10], in_instr[6], 2'b0});
      4'd12: w_imm = XLEN'({{55{in_instr[12]}}, in_instr[12], in_instr[6:5], in_instr[2],
                            in_instr[11:10], in_instr[4:3], 1'b0});
      4'd13: w_imm = XLEN'({{52{in_instr[12]}}, in_instr[12], in_instr[8], in_instr[10:9],
                            in_instr[6], in_instr[7], in_instr[2], in_instr[11],
                            in_instr[5:3], 1'b0});
`endif
      default: w_bad = 1'b1;
    endcase
  end

  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  assign out_imm = r_imm[r_rptr];
  assign out_tag = r_tag[r_rptr];
  assign out_bad = r_bad[r_rptr];

  // Payload is cleared only by rst so an empty stage reads zero; flush just drops the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 2'd0;
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_imm[i] <= '0;
        r_tag[i] <= '0;
        r_bad[i] <= 1'b0;
      end
    end else if (flush) begin
      r_count <= 2'd0;
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
    end else begin
      if (w_push) begin
        r_imm[r_wptr] <= w_imm;
        r_tag[r_wptr] <= in_tag;
        r_bad[r_wptr] <= w_bad;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_in_stable: assert property (@(posedge clk) disable iff (rst)
    (in_valid && !in_ready && !flush) |=>
      (in_valid && $stable(in_instr) && $stable(in_sel) && $stable(in_tag)))
    else $error("in_* changed while stalled");

  always_ff @(posedge clk) begin
    a_xlen: assert (XLEN == 32 || XLEN == 64) else $error("XLEN must be 32 or 64");
  end
`endif

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: XLEN=32 and XLEN=64 instances share one input stream.
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [3:0]  in_sel;
  logic [7:0]  in_tag;

  logic        in_ready, out_valid, out_bad;
  logic [31:0] out_imm;
  logic [7:0]  out_tag;

  logic        in_ready64, out_valid64, out_bad64;
  logic [63:0] out_imm64;
  logic [7:0]  out_tag64;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(32), .TAG_W(8)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_sel(in_sel), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_tag(out_tag), .out_bad(out_bad)
  );

  imm_decode_stage #(.XLEN(64), .TAG_W(8)) u_dut64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr),
    .in_sel(in_sel), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
    .out_tag(out_tag64), .out_bad(out_bad64)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_one(input string name, input logic [31:0] instr, input logic [3:0] sel,
                        input logic [7:0] tag, input logic [31:0] e32, input logic [63:0] e64,
                        input logic ebad);
    in_instr  = instr;
    in_sel    = sel;
    in_tag    = tag;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    check_val({name, "_pre_valid"}, 64'(out_valid), 64'd0);
    step;
    in_valid = 1'b0;
    check_val({name, "_valid"},   64'(out_valid),   64'd1);
    check_val({name, "_valid64"}, 64'(out_valid64), 64'd1);
    check_val({name, "_imm32"},   64'(out_imm),     64'(e32));
    check_val({name, "_imm64"},   out_imm64,        e64);
    check_val({name, "_bad"},     64'(out_bad),     64'(ebad));
    check_val({name, "_bad64"},   64'(out_bad64),   64'(ebad));
    check_val({name, "_tag"},     64'(out_tag),     64'(tag));
    step;
    check_val({name, "_drained"}, 64'(out_valid), 64'd0);
  endtask

  // Fills the buffer with two entries while the consumer is stalled.
  task automatic fill_two(input logic [7:0] t0, input logic [7:0] t1);
    out_ready = 1'b0;
    in_instr  = 32'hFFF00093;
    in_sel    = 4'd0;
    in_tag    = t0;
    in_valid  = 1'b1;
    step;
    in_tag = t1;
    step;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'h0; in_sel = 4'd0; in_tag = 8'h0;
    step;
    step;
    rst = 1'b0;
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_in_ready",  64'(in_ready),  64'd1);
    check_val("rst_out_imm",   64'(out_imm),   64'd0);
    check_val("rst_out_tag",   64'(out_tag),   64'd0);
    check_val("rst_out_bad",   64'(out_bad),   64'd0);

    do_one("i_neg1",  32'hFFF00093, 4'd0, 8'h11, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b0);
    do_one("s_neg4",  32'hFE112E23, 4'd1, 8'h12, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 1'b0);
    do_one("b_neg4",  32'hFE000EE3, 4'd2, 8'h13, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 1'b0);
    do_one("u_pos",   32'h123450B7, 4'd3, 8'h14, 32'h12345000, 64'h00000000_12345000, 1'b0);
    do_one("u_neg",   32'h800000B7, 4'd3, 8'h15, 32'h80000000, 64'hFFFFFFFF_80000000, 1'b0);
    do_one("j_800",   32'h0010006F, 4'd4, 8'h16, 32'h00000800, 64'h00000000_00000800, 1'b0);
    do_one("z_zext",  32'hFFFF8000, 4'd5, 8'h17, 32'h0000001F, 64'h00000000_0000001F, 1'b0);
    do_one("sh_amt",  32'h03F01013, 4'd6, 8'h18, 32'h0000001F, 64'h00000000_0000003F, 1'b0);
    do_one("rsv_7",   32'hFFFFFFFF, 4'd7, 8'h19, 32'h00000000, 64'h0, 1'b1);
    do_one("rsv_15",  32'hFFFFFFFF, 4'd15, 8'h1A, 32'h00000000, 64'h0, 1'b1);
`ifdef IMMGEN_RVC_EN
    do_one("rvc_ci",  32'h000017FD, 4'd8, 8'h1B, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b0);
`else
    do_one("rvc_ci",  32'h000017FD, 4'd8, 8'h1B, 32'h00000000, 64'h0, 1'b1);
`endif

    // back-to-back pushes with simultaneous pop at count=1
    out_ready = 1'b1;
    in_instr  = 32'hFFF00093;
    in_sel    = 4'd0;
    in_valid  = 1'b1;
    in_tag    = 8'hC1;
    step;
    check_val("tp_tag1",   64'(out_tag),  64'hC1);
    check_val("tp_ready1", 64'(in_ready), 64'd1);
    in_tag = 8'hC2;
    step;
    check_val("tp_tag2",   64'(out_tag),  64'hC2);
    check_val("tp_ready2", 64'(in_ready), 64'd1);
    in_tag = 8'hC3;
    step;
    check_val("tp_tag3",   64'(out_tag),   64'hC3);
    check_val("tp_valid3", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    step;
    check_val("tp_drained", 64'(out_valid), 64'd0);

    // backpressure: two entries held, then drained in order
    fill_two(8'hA1, 8'hA2);
    in_valid = 1'b0;
    check_val("bp_in_ready_full", 64'(in_ready),  64'd0);
    check_val("bp_head_tag",      64'(out_tag),   64'hA1);
    check_val("bp_out_valid",     64'(out_valid), 64'd1);
    step;
    check_val("bp_head_held",     64'(out_tag),   64'hA1);
    check_val("bp_imm_held",      64'(out_imm),   64'hFFFFFFFF);
    check_val("bp_still_full",    64'(in_ready),  64'd0);
    out_ready = 1'b1;
    step;
    check_val("bp_second_tag",    64'(out_tag),   64'hA2);
    check_val("bp_in_ready_back", 64'(in_ready),  64'd1);
    step;
    check_val("bp_drained",       64'(out_valid), 64'd0);

    // flush at count=2 with a pending input
    fill_two(8'hB1, 8'hB2);
    in_tag = 8'hB3;
    flush  = 1'b1;
    step;
    flush = 1'b0; in_valid = 1'b0;
    check_val("fl2_out_valid", 64'(out_valid), 64'd0);
    check_val("fl2_in_ready",  64'(in_ready),  64'd1);
    step;
    check_val("fl2_dropped",   64'(out_valid), 64'd0);

    // flush at count=1 overrides a push that would otherwise land
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_tag    = 8'hE1;
    step;
    in_tag = 8'hE2;
    flush  = 1'b1;
    step;
    flush = 1'b0; in_valid = 1'b0;
    check_val("fl1_out_valid", 64'(out_valid), 64'd0);
    check_val("fl1_in_ready",  64'(in_ready),  64'd1);

    // stage still works after flush
    do_one("post_flush", 32'h123450B7, 4'd3, 8'hD1, 32'h12345000, 64'h00000000_12345000, 1'b0);

    // reset mid-transfer at count=2 with a pending input
    fill_two(8'h51, 8'h52);
    in_tag = 8'h53;
    rst    = 1'b1;
    step;
    rst = 1'b0; in_valid = 1'b0;
    check_val("rs_out_valid", 64'(out_valid), 64'd0);
    check_val("rs_in_ready",  64'(in_ready),  64'd1);
    check_val("rs_out_imm",   64'(out_imm),   64'd0);
    check_val("rs_out_imm64", out_imm64,      64'd0);
    check_val("rs_out_tag",   64'(out_tag),   64'd0);
    step;
    check_val("rs_dropped",   64'(out_valid), 64'd0);

    do_one("post_rst", 32'h0010006F, 4'd4, 8'h61, 32'h00000800, 64'h00000000_00000800, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
